// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Stage 0 issues a pixel request with x/y straight from the counters; stage 1 registers
// blank/hsync/vsync one clock later, which is when the pixel generator's registered colour
// comes back, so the returned RGB is gated combinationally by blank_o.
module vga_timing_gen #(
    parameter logic [11:0] H_DISP = 12'd800,
    parameter logic [11:0] H_FP   = 12'd40,
    parameter logic [11:0] H_SYNC = 12'd128,
    parameter logic [11:0] H_BP   = 12'd88,
    parameter logic [11:0] V_DISP = 12'd600,
    parameter logic [11:0] V_FP   = 12'd1,
    parameter logic [11:0] V_SYNC = 12'd4,
    parameter logic [11:0] V_BP   = 12'd23,
    parameter logic        HS_POL = 1'b1,
    parameter logic        VS_POL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rgb_r_i,
    input  logic [7:0]  rgb_g_i,
    input  logic [7:0]  rgb_b_i,
    output logic        data_requst_o,
    output logic [11:0] x_pos_o,
    output logic [11:0] y_pos_o,
    output logic        clk_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic        blank_o,
    output logic [7:0]  rgb_r_o,
    output logic [7:0]  rgb_g_o,
    output logic [7:0]  rgb_b_o
);

    // Totals and sync windows; both totals must stay <= 4095 to fit the 12-bit counters.
    localparam logic [11:0] H_TOTAL    = H_DISP + H_FP + H_SYNC + H_BP;
    localparam logic [11:0] V_TOTAL    = V_DISP + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] H_SYNC_BEG = H_DISP + H_FP;
    localparam logic [11:0] H_SYNC_END = H_DISP + H_FP + H_SYNC;
    localparam logic [11:0] V_SYNC_BEG = V_DISP + V_FP;
    localparam logic [11:0] V_SYNC_END = V_DISP + V_FP + V_SYNC;

    logic [11:0] h_cnt_q;
    logic [11:0] v_cnt_q;
    logic        h_last;
    logic        v_last;
    logic        req;
    logic        in_hsync;
    logic        in_vsync;
    logic        blank_q;
    logic        hs_q;
    logic        vs_q;

    // Stage 0: decode the counter position.
    always_comb begin
        h_last   = (h_cnt_q == H_TOTAL - 12'd1);
        v_last   = (v_cnt_q == V_TOTAL - 12'd1);
        req      = (h_cnt_q < H_DISP) && (v_cnt_q < V_DISP);
        in_hsync = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
        in_vsync = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
    end

    // Raster counters: h wraps every line, v advances only on the last pixel of a line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
        end else if (h_last) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= v_last ? 12'd0 : v_cnt_q + 12'd1;
        end else begin
            h_cnt_q <= h_cnt_q + 12'd1;
        end
    end

    // Stage 1: register blank and syncs one clock behind the request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blank_q <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
        end else begin
            blank_q <= req;
            hs_q    <= in_hsync ? HS_POL : ~HS_POL;
            vs_q    <= in_vsync ? VS_POL : ~VS_POL;
        end
    end

    // Request outputs and colour gating; the DAC samples on the falling pixel-clock edge.
    always_comb begin
        data_requst_o = req;
        x_pos_o       = req ? h_cnt_q : 12'd0;
        y_pos_o       = req ? v_cnt_q : 12'd0;
        clk_o         = ~clk_i;
        blank_o       = blank_q;
        hs_o          = hs_q;
        vs_o          = vs_q;
        rgb_r_o       = blank_q ? rgb_r_i : 8'd0;
        rgb_g_o       = blank_q ? rgb_g_i : 8'd0;
        rgb_b_o       = blank_q ? rgb_b_i : 8'd0;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing for the display pipeline.
- Runs in the 40 MHz pixel domain that feeds the pixel generator, which renders the Tetris playfield and ROM sprites.
- Issues pixel requests with x/y coordinates one cycle ahead of the visible pixel.
- Registers the sync and blank outputs, then gates the returned RGB onto the DAC interface in alignment with them.
- Default timing is 800x600@60 Hz (VESA, 40 MHz).

Parameters:
- H_DISP, 12'd800, active pixels per line
- H_FP, 12'd40, horizontal front porch (clocks)
- H_SYNC, 12'd128, horizontal sync width (clocks)
- H_BP, 12'd88, horizontal back porch (clocks); H_TOTAL = sum of the four = 1056
- V_DISP, 12'd600, active lines per frame
- V_FP, 12'd1, vertical front porch (lines)
- V_SYNC, 12'd4, vertical sync width (lines)
- V_BP, 12'd23, vertical back porch (lines); V_TOTAL = 628
- HS_POL, 1'b1, asserted level of hs_o
- VS_POL, 1'b1, asserted level of vs_o

Ports:
- clk_i  in  1  pixel clock (40 MHz default)
- rst_i  in  1  synchronous active-high reset
- rgb_r_i/rgb_g_i/rgb_b_i  in  8 each  pixel colour, registered by the pixel generator one cycle after the request
- data_requst_o  out  1  current counter position is active video
- x_pos_o  out  12  requested column, 0..H_DISP-1
- y_pos_o  out  12  requested row, 0..V_DISP-1
- clk_o  out  1  DAC clock = ~clk_i (DAC samples mid-cycle)
- hs_o  out  1  horizontal sync
- vs_o  out  1  vertical sync
- blank_o  out  1  display enable, high during visible pixels
- rgb_r_o/rgb_g_o/rgb_b_o  out  8 each  colour to DAC

Behaviour:
- Reset and clocking: one clock domain. Reset is synchronous and active-high on rgb_i... specifically rst_i, sampled on the clk_i rising edge.
- Reset values: h_cnt = 0, v_cnt = 0; hs_o = ~HS_POL, vs_o = ~VS_POL, blank_o = 0; rgb_*_o = 0.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only when h_cnt = H_TOTAL-1; it wraps to 0 from V_TOTAL-1.
  - Simultaneous wrap at (1055, 627) goes to (0, 0) on the next edge.
- Region order per line: active [0, H_DISP-1], then front porch, then sync [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1] = [840, 967], then back porch. Lines follow the same order: vertical sync rows are [601, 604].
- Stage 0 (combinational from the counter registers):
  - data_requst_o = (h_cnt < H_DISP) && (v_cnt < V_DISP).
  - x_pos_o = h_cnt and y_pos_o = v_cnt while the request is high; both are 0 otherwise.
- Stage 1 (registered, one clock of latency from the counters):
  - blank_o <= stage-0 data_requst.
  - hs_o <= HS_POL when h_cnt is in the sync range, else ~HS_POL.
  - vs_o <= VS_POL when v_cnt is in the sync range, else ~VS_POL. vs_o is a function of v_cnt only and changes in step with the line boundary.
- RGB path:
  - rgb_*_o = blank_o ? rgb_*_i : 8'd0, combinational. The pixel generator's one-cycle registered response therefore lands on the same clock as blank_o.
  - Output is forced to 0 whenever blank_o = 0, regardless of rgb_*_i.
- Timing relationships:
  - Total latency from request to visible pixel: exactly 1 clock.
  - Request-to-blank skew: exactly 1 clock, for every pixel including pixel 0 of line 0.
- Reset mid-frame:
  - Counters return to (0, 0) on the next edge and syncs deassert.
  - The first frame after release starts cleanly: data_requst_o is high in the first cycle after release, and blank_o rises one cycle later.
- Widths and parameter checks:
  - All comparisons are 12-bit unsigned.
  - H_TOTAL and V_TOTAL must be <= 4095.
  - Zero-width porches are legal; zero-width sync is not required to work.

Test Plan:
- Reset: assert rst_i for 5 cycles mid-line with h_cnt ~500 → outputs equal the reset values on the first edge. After release, cycle 0 has data_requst_o = 1, x_pos_o = 0, y_pos_o = 0, and blank_o rises exactly 1 cycle later.
- Line timing: count from release → data_requst_o is high for 800 consecutive cycles per line. hs_o = 1 for 128 cycles starting 841 cycles after the line's first request. Line period is 1056 cycles.
- Frame timing: run one frame → 600 lines contain requests, vs_o = 1 for 4×1056 cycles, frame period is 663168 cycles, and (h, v) wraps from (1055, 627) to (0, 0).
- Alignment: model a pixel generator that registers rgb = {x[7:0], y[7:0], 8'hA5} → every cycle with blank_o = 1 shows rgb_r_o equal to the previous cycle's x_pos_o[7:0]. With blank_o = 0, outputs are 0 even when rgb_i = 24'hFFFFFF.
- Polarity: instantiate with HS_POL = 0 and VS_POL = 0 → syncs idle high and pulse low for the same 128-cycle and 4-line windows; all other outputs are unchanged.
- Small-mode sanity: parameters H = 8/2/2/2 and V = 4/1/1/1 → line period 14, frame period 98, x_pos_o sequence 0..7 then 0 held for 6 cycles.
